ntt_addr_seq: RTL and testbench

Parametrised NTT/INTT butterfly address sequencer for the ML-KEM polynomial core. It replaces the fixed 256-point address generator with a generator configurable in transform size and final layer. It adds valid/ready backpressure, per-layer drain gaps that protect the butterfly pipeline from read-after-write hazards, and layer progress reporting. It drives the coefficient RAM read ports (j, j+len) and the zeta ROM index feeding the butterfly unit.

---
 rtl/ntt_addr_seq.sv | 169 ++++++++++++++++
 tb/tb_ntt_addr_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ntt_addr_seq.sv
// Butterfly address sequencer for NTT/INTT: walks layers, groups and offsets, emitting
// coefficient RAM addresses and zeta ROM indices with valid/ready flow and inter-layer drain gaps.
module ntt_addr_seq #(
    parameter int LOG_N       = 8,
    parameter int MIN_LEN_LOG = 1,
    parameter int GAP         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       is_ntt,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [LOG_N-1:0]           addr_j,
    output logic [LOG_N-1:0]           addr_jl,
    output logic [LOG_N-2:0]           addr_zeta,
    output logic [$clog2(LOG_N)-1:0]   layer,
    output logic                       layer_done,
    output logic                       busy,
    output logic                       done
);

    localparam int L  = LOG_N - MIN_LEN_LOG;
    localparam int KW = LOG_N - 1;
    localparam int LW = $clog2(LOG_N);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [KW-1:0]     k_q, k_d;
    logic [LW-1:0]     layer_q, layer_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              out_valid_q, out_valid_d;
    logic [LOG_N-1:0]  addr_j_q, addr_j_d;
    logic [LOG_N-1:0]  addr_jl_q, addr_jl_d;
    logic [LOG_N-2:0]  addr_zeta_q, addr_zeta_d;
    logic              layer_done_q, layer_done_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    int                span;
    logic [LOG_N-1:0]  kx, len_v, g_v, i_v, grp_v;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        k_d          = k_q;
        layer_d      = layer_q;
        gap_d        = gap_q;
        out_valid_d  = 1'b0;
        layer_done_d = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d     = ISSUE;
                    mode_d      = is_ntt;
                    k_d         = '0;
                    layer_d     = '0;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b1;
                end
            end
            ISSUE: begin
                out_valid_d = 1'b1;
                if (out_ready) begin
                    if (k_q == {KW{1'b1}}) begin
                        k_d          = '0;
                        out_valid_d  = 1'b0;
                        layer_done_d = 1'b1;
                        gap_d        = '0;
                        if (layer_q == LW'(L - 1)) begin
                            state_d = FINISH;
                            done_d  = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            DRAIN: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(GAP - 1)) begin
                    state_d     = ISSUE;
                    layer_d     = layer_q + LW'(1);
                    out_valid_d = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat outputs are precomputed from the next counter state so they can be registered;
    // during a stall the next state equals the current one, which keeps them stable.
    always_comb begin
        span        = 0;
        kx          = '0;
        len_v       = '0;
        g_v         = '0;
        i_v         = '0;
        grp_v       = '0;
        addr_j_d    = '0;
        addr_jl_d   = '0;
        addr_zeta_d = '0;
        if (out_valid_d) begin
            span        = mode_d ? (LOG_N - 1 - int'(layer_d)) : (MIN_LEN_LOG + int'(layer_d));
            kx          = LOG_N'(k_d);
            len_v       = LOG_N'(1) << span;
            g_v         = kx >> span;
            i_v         = kx & (len_v - LOG_N'(1));
            grp_v       = LOG_N'(1) << (LOG_N - 1 - span);
            addr_j_d    = (g_v << (span + 1)) | i_v;
            addr_jl_d   = addr_j_d + len_v;
            addr_zeta_d = mode_d ? (LOG_N-1)'(grp_v + g_v)
                                 : (LOG_N-1)'((grp_v << 1) - LOG_N'(1) - g_v);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            k_q          <= '0;
            layer_q      <= '0;
            gap_q        <= '0;
            out_valid_q  <= 1'b0;
            addr_j_q     <= '0;
            addr_jl_q    <= '0;
            addr_zeta_q  <= '0;
            layer_done_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            k_q          <= k_d;
            layer_q      <= layer_d;
            gap_q        <= gap_d;
            out_valid_q  <= out_valid_d;
            addr_j_q     <= addr_j_d;
            addr_jl_q    <= addr_jl_d;
            addr_zeta_q  <= addr_zeta_d;
            layer_done_q <= layer_done_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign addr_j     = addr_j_q;
    assign addr_jl    = addr_jl_q;
    assign addr_zeta  = addr_zeta_q;
    assign layer      = layer_q;
    assign layer_done = layer_done_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ntt_addr_seq.sv
// Directed bench for ntt_addr_seq: default 256-point instance plus a 16-point, GAP=1 instance.
module tb_ntt_addr_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // default instance (LOG_N=8, MIN_LEN_LOG=1, GAP=4)
    logic       start = 1'b0, is_ntt = 1'b0, out_ready = 1'b0;
    logic       out_valid, layer_done, busy, done;
    logic [7:0] addr_j, addr_jl;
    logic [6:0] addr_zeta;
    logic [2:0] layer;

    ntt_addr_seq #(.LOG_N(8), .MIN_LEN_LOG(1), .GAP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .is_ntt(is_ntt), .out_ready(out_ready),
        .out_valid(out_valid), .addr_j(addr_j), .addr_jl(addr_jl), .addr_zeta(addr_zeta),
        .layer(layer), .layer_done(layer_done), .busy(busy), .done(done)
    );

    // small instance (LOG_N=4, MIN_LEN_LOG=1, GAP=1)
    logic       s_start = 1'b0, s_is_ntt = 1'b1, s_ready = 1'b1;
    logic       s_valid, s_ld, s_busy, s_done;
    logic [3:0] s_j, s_jl;
    logic [2:0] s_zeta;
    logic [1:0] s_layer;

    ntt_addr_seq #(.LOG_N(4), .MIN_LEN_LOG(1), .GAP(1)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .is_ntt(s_is_ntt), .out_ready(s_ready),
        .out_valid(s_valid), .addr_j(s_j), .addr_jl(s_jl), .addr_zeta(s_zeta),
        .layer(s_layer), .layer_done(s_ld), .busy(s_busy), .done(s_done)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int nb, nld, done_c, gap_bad, stall_bad, seq_bad, busy_bad;
    int bj [896];
    int bjl[896];
    int bz [896];
    int bl [896];

    int ztab[24] = '{1,1,1,1,1,1,1,1, 2,2,2,2,3,3,3,3, 4,4,5,5,6,6,7,7};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference: layer/offset decomposition by division, straight from the loop nest.
    function automatic void model(input int logn, input int minl, input bit ntt, input int beat,
                                  output int j, output int jl, output int z, output int ly);
        int half, kk, len, g, i, grp;
        half = (1 << logn) / 2;
        ly   = beat / half;
        kk   = beat % half;
        len  = ntt ? (half >> ly) : ((1 << minl) << ly);
        g    = kk / len;
        i    = kk % len;
        j    = g * 2 * len + i;
        jl   = j + len;
        grp  = half / len;
        z    = ntt ? grp + g : 2 * grp - 1 - g;
    endfunction

    task automatic run0(input bit ntt, input bit rnd, input bit poke, input int abort_nb);
        int  j, jl, z, ly, lowrun;
        bit  pv, pr;
        int  pj, pjl, pz, pl;
        nb = 0; nld = 0; done_c = -1; gap_bad = 0; stall_bad = 0; seq_bad = 0; busy_bad = 0;
        lowrun = 0; pv = 0; pr = 0; pj = 0; pjl = 0; pz = 0; pl = 0;
        is_ntt = ntt;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (poke) begin
                start  = 1'b1;
                is_ntt = ~is_ntt;
            end
            if (layer_done) nld++;
            if (!busy) busy_bad++;
            if (pv && !pr && (!out_valid || int'(addr_j) != pj || int'(addr_jl) != pjl ||
                              int'(addr_zeta) != pz || int'(layer) != pl))
                stall_bad++;
            if (done) begin
                done_c = c;
                break;
            end
            if (!out_valid) lowrun++;
            else begin
                if (lowrun != 0 && lowrun != 4) gap_bad++;
                lowrun = 0;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                model(8, 1, ntt, nb, j, jl, z, ly);
                if (nb < 896) begin
                    bj[nb] = int'(addr_j); bjl[nb] = int'(addr_jl);
                    bz[nb] = int'(addr_zeta); bl[nb] = int'(layer);
                end
                if (int'(addr_j) != j || int'(addr_jl) != jl || int'(addr_zeta) != (z % 128) ||
                    int'(layer) != ly)
                    seq_bad++;
                nb++;
                if (nb == abort_nb) break;
            end
            pv = out_valid; pr = out_ready;
            pj = int'(addr_j); pjl = int'(addr_jl); pz = int'(addr_zeta); pl = int'(layer);
            @(posedge clk); #1;
        end
        start     = 1'b0;
        is_ntt    = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int j, jl, z, ly, n1, n1ld, d1c, bad1;

        // reset state
        #2 rst = 1'b1;
        #1;
        chk("reset_outputs", {out_valid, addr_j, addr_jl, addr_zeta, layer, layer_done, busy, done}, 0);
        chk("reset_small", {s_valid, s_j, s_jl, s_zeta, s_layer, s_ld, s_busy, s_done}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // forward, out_ready held high
        run0(1'b1, 1'b0, 1'b0, -1);
        chk("fwd_beats", nb, 896);
        chk("fwd_layer_done", nld, 7);
        chk("fwd_done_cycle", done_c, 920);
        chk("fwd_seq", seq_bad, 0);
        chk("fwd_busy", busy_bad, 0);
        chk("fwd_gap", gap_bad, 0);
        chk("fwd_b0", {bj[0][7:0], bjl[0][7:0], bz[0][7:0], bl[0][7:0]}, {8'd0, 8'd128, 8'd1, 8'd0});
        chk("fwd_b128", {bj[128][7:0], bjl[128][7:0], bz[128][7:0], bl[128][7:0]},
            {8'd0, 8'd64, 8'd2, 8'd1});
        chk("fwd_last", {bj[895][7:0], bjl[895][7:0], bz[895][7:0], bl[895][7:0]},
            {8'd253, 8'd255, 8'd127, 8'd6});
        @(posedge clk); #1;
        chk("fwd_idle_after", {busy, done, out_valid, layer_done}, 0);

        // forward, random backpressure
        run0(1'b1, 1'b1, 1'b0, -1);
        chk("rnd_beats", nb, 896);
        chk("rnd_seq", seq_bad, 0);
        chk("rnd_stall_stable", stall_bad, 0);
        chk("rnd_gap", gap_bad, 0);
        chk("rnd_finished", {31'd0, done_c >= 0}, 1);
        chk("rnd_layer_done", nld, 7);
        @(posedge clk); #1;

        // inverse with start pulsed and is_ntt toggled throughout
        run0(1'b0, 1'b0, 1'b1, -1);
        chk("inv_beats", nb, 896);
        chk("inv_seq", seq_bad, 0);
        chk("inv_done_cycle", done_c, 920);
        chk("inv_b0", {bj[0][7:0], bjl[0][7:0], bz[0][7:0], bl[0][7:0]}, {8'd0, 8'd2, 8'd127, 8'd0});
        chk("inv_b1", {bj[1][7:0], bjl[1][7:0], bz[1][7:0]}, {8'd1, 8'd3, 8'd127});
        chk("inv_b64", {bj[64][7:0], bjl[64][7:0], bz[64][7:0]}, {8'd128, 8'd130, 8'd95});
        chk("inv_last", {bj[895][7:0], bjl[895][7:0], bz[895][7:0], bl[895][7:0]},
            {8'd127, 8'd255, 8'd1, 8'd6});
        @(posedge clk); #1;
        chk("inv_no_restart", {busy, out_valid}, 0);

        // asynchronous reset mid-transform, then a fresh run
        run0(1'b1, 1'b0, 1'b0, 300);
        chk("abort_reached", nb, 300);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", {out_valid, addr_j, addr_jl, addr_zeta, layer, layer_done, busy, done}, 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run0(1'b1, 1'b0, 1'b0, -1);
        chk("post_rst_beats", nb, 896);
        chk("post_rst_seq", seq_bad, 0);
        chk("post_rst_done_cycle", done_c, 920);
        @(posedge clk); #1;

        // small instance: 3 layers x 8 beats, GAP=1
        n1 = 0; n1ld = 0; d1c = -1; bad1 = 0;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (s_ld) n1ld++;
            if (s_done) begin
                d1c = c;
                break;
            end
            if (s_valid) begin
                model(4, 1, 1'b1, n1, j, jl, z, ly);
                if (n1 >= 24 || int'(s_zeta) != ztab[n1] || int'(s_j) != j || int'(s_jl) != jl ||
                    int'(s_layer) != ly)
                    bad1++;
                n1++;
            end
            @(posedge clk); #1;
        end
        chk("small_beats", n1, 24);
        chk("small_seq", bad1, 0);
        chk("small_done_cycle", d1c, 26);
        chk("small_layer_done", n1ld, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
